// File: rtl/cmd_responder_pkg.sv
// Shared types and defaults for the command responder and its byte receiver.
package cmd_responder_pkg;

    localparam int DEFAULT_BAUD_CYCLES = 2604;
    localparam int FRAME_BITS          = 10;   // start + 8 data + stop

    typedef enum logic {ASM_HIGH, ASM_LOW}  asm_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT}  tx_state_t;
    typedef enum logic {RX_IDLE, RX_BUSY}   rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: synchronises RX, finds the start edge, samples mid-bit,
// and reports a good byte (rx_rdy) or a bad stop bit (rx_err).
module uart_byte_rx
    import cmd_responder_pkg::*;
#(
    parameter int BAUD_CYCLES = DEFAULT_BAUD_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       rx_err,
    output logic       rx_start
);

    localparam int                BAUD_W    = $clog2(BAUD_CYCLES);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CYCLES - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(BAUD_CYCLES / 2 - 1);
    localparam int                BIT_W     = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0]  STOP_IDX  = BIT_W'(FRAME_BITS - 1);

    logic              r_rx_meta;
    logic              r_rx_sync;
    logic              r_rx_prev;
    rx_state_t         r_state;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [7:0]        r_shift;
    logic [7:0]        r_data;
    logic              r_rdy;
    logic              r_err;
    logic              r_start;

    logic w_fall;
    logic w_baud_hit;

    assign w_fall     = r_rx_prev & ~r_rx_sync;
    // The start bit is sampled half a bit in; every later bit a full bit after.
    assign w_baud_hit = (r_baud_cnt == ((r_bit_idx == '0) ? HALF_LAST : BAUD_LAST));

    // NOTE: non-blocking assignments so every flop here samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_state    <= RX_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_rdy      <= 1'b0;
            r_err      <= 1'b0;
            r_start    <= 1'b0;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            r_rdy     <= 1'b0;
            r_err     <= 1'b0;
            r_start   <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state    <= RX_BUSY;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_start    <= 1'b1;
                    end
                end
                RX_BUSY: begin
                    if (!w_baud_hit) begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end else begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= r_bit_idx + 1'b1;
                        if (r_bit_idx == '0) begin
                            if (r_rx_sync) begin
                                r_state   <= RX_IDLE;   // glitch, not a real start bit
                                r_bit_idx <= '0;
                            end
                        end else if (r_bit_idx == STOP_IDX) begin
                            r_state   <= RX_IDLE;
                            r_bit_idx <= '0;
                            if (r_rx_sync) begin
                                r_data <= r_shift;
                                r_rdy  <= 1'b1;
                            end else begin
                                r_err  <= 1'b1;
                            end
                        end else begin
                            r_shift <= {r_rx_sync, r_shift[7:1]};
                        end
                    end
                end
            endcase
        end
    end

    assign rx_data  = r_data;
    assign rx_rdy   = r_rdy;
    assign rx_err   = r_err;
    assign rx_start = r_start;

endmodule

// File: rtl/cmd_responder.sv
// Remote command endpoint: assembles two received bytes into a 16-bit command
// and transmits one-byte responses, full duplex over an 8N1 link.
module cmd_responder
    import cmd_responder_pkg::*;
#(
    parameter int BAUD_CYCLES  = DEFAULT_BAUD_CYCLES,
    parameter int BYTE_TIMEOUT = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        snd_resp,
    output logic        resp_sent,
    output logic        frame_err
);

    localparam int                BAUD_W    = $clog2(BAUD_CYCLES);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CYCLES - 1);
    localparam int                BIT_W     = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0]  STOP_IDX  = BIT_W'(FRAME_BITS - 1);
    localparam int                TMO_W     = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_LIMIT = TMO_W'(BYTE_TIMEOUT);

    logic [7:0] w_rx_data;
    logic       w_rx_rdy;
    logic       w_rx_err;
    logic       w_rx_start;

    uart_byte_rx #(
        .BAUD_CYCLES(BAUD_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .i_rx     (RX),
        .rx_data  (w_rx_data),
        .rx_rdy   (w_rx_rdy),
        .rx_err   (w_rx_err),
        .rx_start (w_rx_start)
    );

    asm_state_t       r_asm;
    logic [7:0]       r_high;
    logic [15:0]      r_cmd;
    logic             r_cmd_rdy;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo_run;

    // Later assignments win, so a completing command's set beats any clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_asm     <= ASM_HIGH;
            r_high    <= '0;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_tmo_cnt <= '0;
            r_tmo_run <= 1'b0;
        end else begin
            if (clr_cmd_rdy || (w_rx_start && r_asm == ASM_HIGH))
                r_cmd_rdy <= 1'b0;

            if (w_rx_start) begin
                r_tmo_run <= 1'b0;
            end else if (r_tmo_run) begin
                if (r_tmo_cnt == TMO_LIMIT) begin
                    r_asm     <= ASM_HIGH;
                    r_tmo_run <= 1'b0;
                    r_tmo_cnt <= '0;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 1'b1;
                end
            end

            if (w_rx_err) begin
                r_asm     <= ASM_HIGH;
                r_tmo_run <= 1'b0;
                r_tmo_cnt <= '0;
            end else if (w_rx_rdy) begin
                r_tmo_cnt <= '0;
                case (r_asm)
                    ASM_HIGH: begin
                        r_high    <= w_rx_data;
                        r_asm     <= ASM_LOW;
                        r_tmo_run <= 1'b1;
                    end
                    ASM_LOW: begin
                        r_cmd     <= {r_high, w_rx_data};
                        r_cmd_rdy <= 1'b1;
                        r_asm     <= ASM_HIGH;
                        r_tmo_run <= 1'b0;
                    end
                endcase
            end
        end
    end

    tx_state_t         r_tx_state;
    logic [9:0]        r_tx_shift;
    logic [BAUD_W-1:0] r_tx_baud;
    logic [BIT_W-1:0]  r_tx_bit;
    logic              r_resp_sent;

    // TX is the shifter LSB; refilling with ones leaves the line idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state  <= TX_IDLE;
            r_tx_shift  <= '1;
            r_tx_baud   <= '0;
            r_tx_bit    <= '0;
            r_resp_sent <= 1'b0;
        end else begin
            r_resp_sent <= 1'b0;
            case (r_tx_state)
                TX_IDLE: begin
                    if (snd_resp) begin
                        r_tx_shift <= {1'b1, resp, 1'b0};
                        r_tx_baud  <= '0;
                        r_tx_bit   <= '0;
                        r_tx_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (r_tx_baud != BAUD_LAST) begin
                        r_tx_baud <= r_tx_baud + 1'b1;
                    end else begin
                        r_tx_baud  <= '0;
                        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                        if (r_tx_bit == STOP_IDX) begin
                            r_tx_bit    <= '0;
                            r_tx_state  <= TX_IDLE;
                            r_resp_sent <= 1'b1;
                        end else begin
                            r_tx_bit <= r_tx_bit + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign TX        = r_tx_shift[0];
    assign cmd       = r_cmd;
    assign cmd_rdy   = r_cmd_rdy;
    assign resp_sent = r_resp_sent;
    assign frame_err = w_rx_err;

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder: a table of two-byte commands plus
// hand-written sequences for response TX, framing errors, timeout and reset.
module tb_cmd_responder;

    localparam int BAUD = 16;
    localparam int TMO  = 400;

    logic        clk = 1'b0;
    logic        rst;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        snd_resp;
    logic        resp_sent;
    logic        frame_err;

    always #5 clk = ~clk;

    cmd_responder #(
        .BAUD_CYCLES  (BAUD),
        .BYTE_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .snd_resp    (snd_resp),
        .resp_sent   (resp_sent),
        .frame_err   (frame_err)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_sent = 0;
    int n_ferr = 0;

    always @(negedge clk) begin
        if (resp_sent === 1'b1) n_sent++;
        if (frame_err === 1'b1) n_ferr++;
    end

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        clr;
        logic [15:0] exp_cmd;
    } vec_t;

    vec_t       vecs [5];
    logic [9:0] exp_tx;
    logic [7:0] remote_byte;
    int         s0;
    int         f0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BAUD) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit hit, got no summary, expected completion");
        $fatal(1);
    end

    initial begin
        RX = 1'b1; rst = 1'b1; clr_cmd_rdy = 1'b0; snd_resp = 1'b0; resp = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx",        32'(TX),        32'h1);
        check("rst_cmd",       32'(cmd),       32'h0);
        check("rst_cmd_rdy",   32'(cmd_rdy),   32'h0);
        check("rst_resp_sent", 32'(resp_sent), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        idle(4);

        vecs[0] = '{hi: 8'h00, lo: 8'h00, clr: 1'b0, exp_cmd: 16'h0000};
        vecs[1] = '{hi: 8'h2B, lo: 8'hCD, clr: 1'b1, exp_cmd: 16'h2BCD};
        vecs[2] = '{hi: 8'hFF, lo: 8'hFF, clr: 1'b0, exp_cmd: 16'hFFFF};
        vecs[3] = '{hi: 8'h80, lo: 8'h01, clr: 1'b1, exp_cmd: 16'h8001};
        vecs[4] = '{hi: 8'h55, lo: 8'hAA, clr: 1'b0, exp_cmd: 16'h55AA};

        for (int v = 0; v < 5; v++) begin
            send_byte(vecs[v].hi, 1'b1);
            send_byte(vecs[v].lo, 1'b1);
            check($sformatf("vec%0d_cmd", v), 32'(cmd),     32'(vecs[v].exp_cmd));
            check($sformatf("vec%0d_rdy", v), 32'(cmd_rdy), 32'h1);
            if (vecs[v].clr) begin
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                check($sformatf("vec%0d_clr_rdy", v), 32'(cmd_rdy), 32'h0);
                check($sformatf("vec%0d_clr_cmd", v), 32'(cmd),     32'(vecs[v].exp_cmd));
            end
            idle(3);
        end

        // Response A5, with a second request mid-frame that must be ignored.
        exp_tx = 10'b11_0100_1010;
        remote_byte = 8'h00;
        s0 = n_sent;
        resp = 8'hA5;
        snd_resp = 1'b1;
        @(negedge clk);
        snd_resp = 1'b0;
        for (int c = 0; c < 10 * BAUD; c++) begin
            if (c % BAUD == 0)
                check($sformatf("tx_bit%0d_head", c / BAUD), 32'(TX), 32'(exp_tx[c / BAUD]));
            if (c % BAUD == BAUD - 1)
                check($sformatf("tx_bit%0d_tail", c / BAUD), 32'(TX), 32'(exp_tx[c / BAUD]));
            if (c % BAUD == BAUD / 2 && c / BAUD >= 1 && c / BAUD <= 8)
                remote_byte[c / BAUD - 1] = TX;
            if (c == 3 * BAUD + 2) begin
                snd_resp = 1'b1;
                resp = 8'h00;
            end else begin
                snd_resp = 1'b0;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("tx_resp_sent_count", 32'(n_sent - s0), 32'h1);
        check("tx_idle_after",      32'(TX),          32'h1);
        check("tx_remote_byte",     32'(remote_byte), 32'hA5);

        // Bad stop bit on a high byte, then a clean command.
        f0 = n_ferr;
        send_byte(8'h77, 1'b0);
        idle(2 * BAUD);
        check("ferr_pulse_count", 32'(n_ferr - f0), 32'h1);
        check("ferr_cmd_held",    32'(cmd),         32'h55AA);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("ferr_next_cmd", 32'(cmd),     32'h1234);
        check("ferr_next_rdy", 32'(cmd_rdy), 32'h1);
        idle(3);

        // High byte abandoned past the inter-byte timeout.
        send_byte(8'hFF, 1'b1);
        idle(TMO + 10);
        send_byte(8'h01, 1'b1);
        check("tmo_no_rdy",   32'(cmd_rdy), 32'h0);
        check("tmo_cmd_held", 32'(cmd),     32'h1234);
        send_byte(8'h02, 1'b1);
        check("tmo_cmd", 32'(cmd),     32'h0102);
        check("tmo_rdy", 32'(cmd_rdy), 32'h1);
        idle(3);

        // Reset in the middle of a response frame while cmd_rdy is set.
        resp = 8'h0F;
        snd_resp = 1'b1;
        @(negedge clk);
        snd_resp = 1'b0;
        repeat (5 * BAUD + 4) @(negedge clk);
        check("rstA_tx_before", 32'(TX), 32'h0);
        rst = 1'b1;
        #1;
        check("rstA_tx",      32'(TX),      32'h1);
        check("rstA_cmd_rdy", 32'(cmd_rdy), 32'h0);
        check("rstA_cmd",     32'(cmd),     32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = n_sent;
        idle(12 * BAUD);
        check("rstA_no_resp_sent", 32'(n_sent - s0), 32'h0);
        check("rstA_tx_idle",      32'(TX),          32'h1);

        // Reset in the middle of a low byte; the next full command must land.
        send_byte(8'h5A, 1'b1);
        fork
            send_byte(8'h3C, 1'b1);
            begin
                repeat (4 * BAUD + 3) @(negedge clk);
                rst = 1'b1;
                #1;
                check("rstB_cmd",     32'(cmd),     32'h0);
                check("rstB_cmd_rdy", 32'(cmd_rdy), 32'h0);
                check("rstB_tx",      32'(TX),      32'h1);
            end
        join
        @(negedge clk);
        rst = 1'b0;
        idle(4);
        check("rstB_partial_cmd", 32'(cmd),     32'h0);
        check("rstB_partial_rdy", 32'(cmd_rdy), 32'h0);
        send_byte(8'hC3, 1'b1);
        send_byte(8'h96, 1'b1);
        check("rstB_next_cmd", 32'(cmd),     32'hC396);
        check("rstB_next_rdy", 32'(cmd_rdy), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_responder.md
CMD_RESPONDER -- requirements
Module: cmd_responder

Interface
REQ-001 Parameter BAUD_CYCLES, default 2604: clocks per UART bit.
REQ-002 Parameter BYTE_TIMEOUT, default 1_000_000: max clocks from high-byte stop to low-byte start.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 RX  in  1  serial line from remote commander (8N1, LSB first).
REQ-006 TX  out  1  serial line to remote commander (8N1, LSB first).
REQ-007 cmd  out  16  last assembled command, high byte first on the wire.
REQ-008 cmd_rdy  out  1  level; a valid command is held on cmd.
REQ-009 clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy.
REQ-010 resp  in  8  response byte to transmit.
REQ-011 snd_resp  in  1  one-cycle request to transmit resp.
REQ-012 resp_sent  out  1  one-cycle pulse when the response stop bit completes.
REQ-013 frame_err  out  1  one-cycle pulse on a bad stop bit.

Function
REQ-014 RX shall be double-flopped, with flops resetting to 1, before any use.
REQ-015 Receiver: a falling edge of synced RX while idle starts a frame; bits shall be sampled at BAUD_CYCLES/2, then every BAUD_CYCLES; 8 data bits LSB first, then the stop bit.
REQ-016 Stop bit = 0 shall pulse frame_err, discard the byte and return the assembler to HIGH.
REQ-017 Assembler FSM states: HIGH, LOW.
- HIGH + good byte: latch the high byte; go to LOW; start the timeout counter.
- LOW + good byte: update cmd = {high, low} and set cmd_rdy on the next clock; go to HIGH.
REQ-018 In LOW, the timeout counter reaching BYTE_TIMEOUT before a start edge shall discard the high byte and return to HIGH; cmd shall be unchanged.
REQ-019 cmd_rdy shall clear on clr_cmd_rdy or on the start edge of a new HIGH byte; if set and clear occur in the same cycle, set wins.
REQ-020 cmd shall hold its value until the next complete command; a partial command never alters cmd.
REQ-021 Transmitter FSM states: IDLE, SHIFT.
- snd_resp in IDLE loads {1, resp, 0} into a 10-bit shifter.
- TX shall change on bit boundaries only; the first bit (start 0) is driven within 1 clock of snd_resp.
REQ-022 snd_resp while in SHIFT shall be ignored; the frame in progress is not disturbed.
REQ-023 After the 10th bit period, resp_sent shall pulse for 1 clock and the transmitter returns to IDLE; total frame = 10*BAUD_CYCLES clocks.
REQ-024 Receiver and transmitter shall operate independently (full duplex).
REQ-025 Baud and bit counters shall be sized by $clog2 of their limits; no wrap past terminal count.

Reset
REQ-026 rst shall immediately force: TX=1, cmd=0, cmd_rdy=0, resp_sent=0, frame_err=0, both FSMs idle (HIGH / IDLE), all counters 0.
REQ-027 rst asserted mid-frame shall abort the frame; after release, the receiver shall wait for a fresh falling edge.

Structure
REQ-028 The assembler and transmitter state enums and the default BAUD_CYCLES shall live in the shared test/design package.
REQ-029 The byte receiver shall be one sub-module, uart_byte_rx (rx_data[7:0], rx_rdy, rx_err, rx_start); assembly and TX shall stay in cmd_responder.

Verification
REQ-030 Drive the wire with a RemoteComm-style sender, cmd 16'h0000 -> cmd==16'h0000, cmd_rdy=1 within 1 clock of the 2nd stop bit.
REQ-031 Send 16'h2BCD, then pulse clr_cmd_rdy -> cmd==16'h2BCD; cmd_rdy=0 the next clock.
REQ-032 Pulse snd_resp with resp=8'hA5 -> TX bits 0,1,0,1,0,0,1,0,1,1, each BAUD_CYCLES wide; resp_sent pulses once; the remote end reports resp==8'hA5.
REQ-033 Send a high byte with stop bit 0 -> frame_err pulse; the next two good bytes 8'h12, 8'h34 give cmd==16'h1234.
REQ-034 Send high byte 8'hFF, then idle for BYTE_TIMEOUT+10 clocks, then 8'h01, 8'h02 -> cmd==16'h0102 with no 16'hFF01.
REQ-035 Assert rst mid-way through a low byte and mid-way through a TX frame -> TX=1 and cmd_rdy=0 immediately; the next full command is received correctly.
